// File: rtl/trachtenberg_mul_arbiter_pkg.sv
// trachtenberg_pkg: arbiter FSM states, tag sizing and defaults shared with the multiplier
package trachtenberg_pkg;
    localparam int TRACHT_WIDTH = 5;
    localparam int TRACHT_LATENCY = 9;
    typedef enum logic [1:0] {IDLE, ISSUE, GAP} arb_state_e;
    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/trachtenberg_mul_arbiter_rr_pick.sv
// tracht_rr_pick: combinational round-robin picker, first request at or after the pointer
module tracht_rr_pick
    import trachtenberg_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TW = tag_w(NREQ)
) (
    input  logic [NREQ-1:0] ireq,
    input  logic [TW-1:0]   iptr,
    output logic [NREQ-1:0] ogrant,
    output logic [TW-1:0]   oidx,
    output logic            oany
);
    logic [TW-1:0] j;
    always_comb begin
        ogrant = '0;
        oidx = '0;
        oany = 1'b0;
        j = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = TW'((int'(iptr) + i) % NREQ);
            if (!oany && ireq[j]) begin
                oany = 1'b1;
                oidx = j;
                ogrant[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/trachtenberg_mul_arbiter.sv
// trachtenberg_mul_arbiter: shares one fixed-latency multiplier between NREQ requesters.
// Define TRACHT_ARB_CHECK_EN to add imul_valid and the sticky oerr consistency flag.
module trachtenberg_mul_arbiter
    import trachtenberg_pkg::*;
#(
    parameter int WIDTH = TRACHT_WIDTH,
    parameter int NREQ = 4,
    parameter int LATENCY = TRACHT_LATENCY,
    parameter int ISSUE_GAP = 1
) (
    input  logic                  iclk,
    input  logic                  irst_n,
    input  logic [NREQ-1:0]       ireq,
    input  logic [NREQ*WIDTH-1:0] ia,
    input  logic [NREQ*WIDTH-1:0] ib,
    output logic [NREQ-1:0]       ogrant,
    output logic                  omul_start,
    output logic [WIDTH-1:0]      omul_a,
    output logic [WIDTH-1:0]      omul_b,
    input  logic [2*WIDTH-1:0]    imul_res,
`ifdef TRACHT_ARB_CHECK_EN
    input  logic                  imul_valid,
    output logic                  oerr,
`endif
    output logic [2*WIDTH-1:0]    ores,
    output logic [NREQ-1:0]       ovalid,
    output logic                  obusy
);
    localparam int TW = tag_w(NREQ);
    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

    arb_state_e state;
    logic [GW-1:0] gcnt;
    logic [TW-1:0] ptr, pick_idx, issue_tag;
    logic [NREQ-1:0] pick_grant;
    logic pick_any, fire;
    logic [LATENCY-1:0] vpipe;
    logic [LATENCY-1:0][TW-1:0] tpipe;

    tracht_rr_pick #(.NREQ(NREQ), .TW(TW)) u_pick (
        .ireq(ireq),
        .iptr(ptr),
        .ogrant(pick_grant),
        .oidx(pick_idx),
        .oany(pick_any)
    );

    // GAP state is exactly "gap counter nonzero", so it doubles as the issue inhibit
    assign fire = irst_n && (state != GAP) && pick_any;
    assign ogrant = fire ? pick_grant : '0;
    assign obusy = (|vpipe) || omul_start || (|ovalid);

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state <= IDLE;
            gcnt <= '0;
            ptr <= '0;
        end else if (fire) begin
            state <= (ISSUE_GAP > 1) ? GAP : ISSUE;
            gcnt <= GW'(ISSUE_GAP - 1);
            ptr <= (pick_idx == TW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end else if (state == GAP) begin
            gcnt <= gcnt - 1'b1;
            state <= (gcnt != GW'(1)) ? GAP : (|ireq ? ISSUE : IDLE);
        end else begin
            state <= IDLE;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            omul_start <= 1'b0;
            omul_a <= '0;
            omul_b <= '0;
            issue_tag <= '0;
            vpipe <= '0;
            tpipe <= '0;
            ores <= '0;
            ovalid <= '0;
        end else begin
            omul_start <= fire;
            omul_a <= fire ? ia[pick_idx*WIDTH +: WIDTH] : omul_a;
            omul_b <= fire ? ib[pick_idx*WIDTH +: WIDTH] : omul_b;
            issue_tag <= fire ? pick_idx : issue_tag;
            vpipe <= LATENCY'({vpipe, omul_start});
            tpipe <= (LATENCY*TW)'({tpipe, issue_tag});
            ores <= vpipe[LATENCY-1] ? imul_res : ores;
            ovalid <= vpipe[LATENCY-1] ? (NREQ'(1) << tpipe[LATENCY-1]) : '0;
        end
    end

`ifdef TRACHT_ARB_CHECK_EN
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n)
            oerr <= 1'b0;
        else if (imul_valid != vpipe[LATENCY-1])
            oerr <= 1'b1;
    end
`endif
endmodule
